// File: rtl/mem2_pipe_if.sv
// MEM2 stage bundle: MEM1 instruction handoff, data-memory responses, WB handoff and forwarding.
// "slave" is the stage's view and "master" is the environment's view.
interface mem2_pipe_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic              in_load_i;
  logic              in_store_i;
  logic              in_sign_i;
  logic [1:0]        in_size_i;
  logic [DATA_W-1:0] in_exe_result_i;
  logic [4:0]        in_dest_i;
  logic              in_we_i;
  logic [31:0]       in_pc_i;
  logic              dm_rsp_valid_i;
  logic [DATA_W-1:0] dm_rsp_data_i;
  logic              wb_valid_o;
  logic              wb_ready_i;
  logic [4:0]        wb_dest_o;
  logic              wb_we_o;
  logic [DATA_W-1:0] wb_result_o;
  logic [DATA_W-1:0] wb_addr_o;
  logic [31:0]       wb_pc_o;
  logic              wb_misalign_o;
  logic [4:0]        fwd_dest_o;
  logic [DATA_W-1:0] fwd_data_o;
  logic              fwd_data_ok_o;
  logic              ls_o;
  logic              rsp_ovf_o;

  modport slave (
    input  in_valid_i, in_load_i, in_store_i, in_sign_i, in_size_i, in_exe_result_i,
           in_dest_i, in_we_i, in_pc_i, dm_rsp_valid_i, dm_rsp_data_i, wb_ready_i,
    output in_ready_o, wb_valid_o, wb_dest_o, wb_we_o, wb_result_o, wb_addr_o, wb_pc_o,
           wb_misalign_o, fwd_dest_o, fwd_data_o, fwd_data_ok_o, ls_o, rsp_ovf_o
  );

  modport master (
    output in_valid_i, in_load_i, in_store_i, in_sign_i, in_size_i, in_exe_result_i,
           in_dest_i, in_we_i, in_pc_i, dm_rsp_valid_i, dm_rsp_data_i, wb_ready_i,
    input  in_ready_o, wb_valid_o, wb_dest_o, wb_we_o, wb_result_o, wb_addr_o, wb_pc_o,
           wb_misalign_o, fwd_dest_o, fwd_data_o, fwd_data_ok_o, ls_o, rsp_ovf_o
  );
endinterface

// File: rtl/mem2_pipe.sv
// MEM2 pipeline stage: holds one instruction, matches loads with in-order data-memory
// response beats from a small FIFO, formats load data and hands results to WB.
module mem2_pipe #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  mem2_pipe_if.slave  bus
);
  localparam int unsigned OFF_W = $clog2(DATA_W / 8);
  localparam int unsigned IDX_W = $clog2(RSP_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {ST_EMPTY, ST_WAIT, ST_FULL} state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic              fifo_empty, fifo_full, push, pop, pop_wait, ovf_q;
  logic [DATA_W-1:0] head;

  logic              load_q, store_q, sign_q, we_q, misalign_q;
  logic [1:0]        size_q;
  logic [4:0]        dest_q;
  logic [31:0]       pc_q;
  logic [DATA_W-1:0] addr_q, result_q;

  logic              accept, in_ready_c, wb_valid_c, fwd_ok_c, ls_c;
  logic [4:0]        fwd_dest_c;
  logic [DATA_W-1:0] fwd_data_c;

  // Size 3 on a 32-bit beat degrades to a word access.
  function automatic logic [1:0] eff_size(input logic [1:0] size);
    return (DATA_W == 32 && size == 2'd3) ? 2'd2 : size;
  endfunction

  function automatic logic [OFF_W-1:0] align_mask(input logic [1:0] es);
    case (es)
      2'd0:    return '0;
      2'd1:    return OFF_W'(1);
      2'd2:    return OFF_W'(3);
      default: return OFF_W'(7);
    endcase
  endfunction

  function automatic logic misaligned(input logic [OFF_W-1:0] off, input logic [1:0] size);
    return (off & align_mask(eff_size(size))) != '0;
  endfunction

  // Lane index comes from the offset with its sub-size bits cleared, so misaligned
  // accesses still read the enclosing naturally-aligned lane.
  function automatic logic [DATA_W-1:0] fmt_load(input logic [DATA_W-1:0] beat,
                                                 input logic [OFF_W-1:0]  off,
                                                 input logic [1:0]        size,
                                                 input logic              sign);
    logic [1:0]        es;
    logic [OFF_W-1:0]  lane_off;
    logic [DATA_W-1:0] shifted, mask;
    logic              msb;
    es       = eff_size(size);
    lane_off = off & ~align_mask(es);
    shifted  = beat >> {lane_off, 3'b000};
    case (es)
      2'd0:    begin mask = DATA_W'(8'hFF);         msb = shifted[7];  end
      2'd1:    begin mask = DATA_W'(16'hFFFF);      msb = shifted[15]; end
      2'd2:    begin mask = DATA_W'(32'hFFFF_FFFF); msb = shifted[31]; end
      default: begin mask = '1;                     msb = 1'b0;        end
    endcase
    return (shifted & mask) | ({DATA_W{sign & msb}} & ~mask);
  endfunction

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                      (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
  assign head       = fifo_mem[rd_ptr_q[IDX_W-1:0]];

  assign accept   = bus.in_valid_i & in_ready_c;
  assign pop_wait = (state_q == ST_WAIT) & ~fifo_empty;
  assign pop      = (accept & bus.in_load_i & ~fifo_empty) | pop_wait;
  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign push     = bus.dm_rsp_valid_i & (~fifo_full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (bus.dm_rsp_valid_i & fifo_full & ~pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[IDX_W-1:0]] <= bus.dm_rsp_data_i;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY, ST_FULL: begin
        if (accept)
          state_d = (bus.in_load_i & fifo_empty) ? ST_WAIT : ST_FULL;
        else if (state_q == ST_FULL && bus.wb_ready_i)
          state_d = ST_EMPTY;
      end
      ST_WAIT: if (!fifo_empty) state_d = ST_FULL;
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output decode from the held state and payload.
  always_comb begin
    in_ready_c = (state_q == ST_EMPTY) | ((state_q == ST_FULL) & bus.wb_ready_i);
    wb_valid_c = (state_q == ST_FULL);
    fwd_ok_c   = (state_q == ST_FULL);
    fwd_dest_c = dest_q & {5{(state_q != ST_EMPTY) & we_q}};
    fwd_data_c = result_q & {DATA_W{fwd_ok_c}};
    ls_c       = (load_q | store_q) & (state_q != ST_EMPTY);
  end

  // Payload capture on accept; a waiting load fills its result when its beat pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      sign_q     <= 1'b0;
      size_q     <= 2'd0;
      dest_q     <= 5'd0;
      we_q       <= 1'b0;
      pc_q       <= 32'd0;
      addr_q     <= '0;
      result_q   <= '0;
      misalign_q <= 1'b0;
    end else if (accept) begin
      load_q     <= bus.in_load_i;
      store_q    <= bus.in_store_i;
      sign_q     <= bus.in_sign_i;
      size_q     <= bus.in_size_i;
      dest_q     <= bus.in_dest_i;
      we_q       <= bus.in_we_i;
      pc_q       <= bus.in_pc_i;
      addr_q     <= bus.in_exe_result_i;
      misalign_q <= (bus.in_load_i | bus.in_store_i) &
                    misaligned(bus.in_exe_result_i[OFF_W-1:0], bus.in_size_i);
      if (!bus.in_load_i)
        result_q <= bus.in_exe_result_i;
      else if (!fifo_empty)
        result_q <= fmt_load(head, bus.in_exe_result_i[OFF_W-1:0], bus.in_size_i, bus.in_sign_i);
    end else if (pop_wait) begin
      result_q <= fmt_load(head, addr_q[OFF_W-1:0], size_q, sign_q);
    end
  end

  assign bus.in_ready_o    = in_ready_c;
  assign bus.wb_valid_o    = wb_valid_c;
  assign bus.wb_dest_o     = dest_q;
  assign bus.wb_we_o       = we_q;
  assign bus.wb_result_o   = result_q;
  assign bus.wb_addr_o     = addr_q;
  assign bus.wb_pc_o       = pc_q;
  assign bus.wb_misalign_o = misalign_q;
  assign bus.fwd_dest_o    = fwd_dest_c;
  assign bus.fwd_data_o    = fwd_data_c;
  assign bus.fwd_data_ok_o = fwd_ok_c;
  assign bus.ls_o          = ls_c;
  assign bus.rsp_ovf_o     = ovf_q;
endmodule

// File: tb/tb_mem2_pipe.sv
// Bench for mem2_pipe (64-bit beats, 2-entry response FIFO): directed scenarios plus
// random traffic, with a scoreboard monitor comparing every WB handoff to a byte-level model.
module tb_mem2_pipe;
  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic ovf_model = 1'b0;

  typedef struct {
    logic        load, store, sign, we;
    logic [1:0]  size;
    logic [63:0] exe;
    logic [4:0]  dest;
    logic [31:0] pc;
  } rec_t;

  rec_t        exp_q[$];
  logic [63:0] beat_q[$];

  mem2_pipe_if #(.DATA_W(DW)) bus ();
  mem2_pipe #(.DATA_W(DW), .RSP_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "global time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int acc_bytes(input logic [1:0] size);
    if (size == 2'd3 && DW == 32) return 4;
    return 1 << size;
  endfunction

  // Reference load: pick the aligned group of bytes containing the offset, then extend.
  function automatic logic [63:0] model_load(input logic [63:0] beat, input logic [63:0] addr,
                                             input logic [1:0] size, input logic sign);
    int n, off, start;
    logic [63:0] v;
    n     = acc_bytes(size);
    off   = int'(addr % 64'(DW / 8));
    start = (off / n) * n;
    v     = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = beat[8*(start+i) +: 8];
    if (sign && (8 * n < int'(DW)) && v[8*n-1])
      for (int b = 8 * n; b < int'(DW); b++) v[b] = 1'b1;
    return v;
  endfunction

  // Scoreboard: handoffs pop, accepts push, beats feed the model FIFO.
  always @(negedge clk) begin
    rec_t r;
    logic [63:0] beat, er;
    int pending, n, off;
    if (rst) begin
      exp_q.delete();
      beat_q.delete();
      ovf_model = 1'b0;
    end else begin
      if (bus.wb_valid_o && bus.wb_ready_i) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 64'(bus.wb_valid_o), 64'd0);
        end else begin
          r  = exp_q.pop_front();
          er = r.exe;
          if (r.load) begin
            if (beat_q.size() == 0) check("wb_no_beat", 64'(beat_q.size()), 64'd1);
            else begin
              beat = beat_q.pop_front();
              er   = model_load(beat, r.exe, r.size, r.sign);
            end
          end
          n   = acc_bytes(r.size);
          off = int'(r.exe % 64'(DW / 8));
          check("wb_result", bus.wb_result_o, er);
          check("wb_addr", bus.wb_addr_o, r.exe);
          check("wb_dest", 64'(bus.wb_dest_o), 64'(r.dest));
          check("wb_we", 64'(bus.wb_we_o), 64'(r.we));
          check("wb_pc", 64'(bus.wb_pc_o), 64'(r.pc));
          check("wb_misalign", 64'(bus.wb_misalign_o),
                64'((r.load || r.store) && (off % n != 0)));
        end
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        r.load = bus.in_load_i; r.store = bus.in_store_i; r.sign = bus.in_sign_i;
        r.we = bus.in_we_i; r.size = bus.in_size_i; r.exe = bus.in_exe_result_i;
        r.dest = bus.in_dest_i; r.pc = bus.in_pc_i;
        exp_q.push_back(r);
      end
      if (bus.dm_rsp_valid_i) begin
        // Beats still owed to the FIFO = queued beats minus loads that have not yet left it.
        pending = 0;
        foreach (exp_q[i]) if (exp_q[i].load) pending++;
        if (int'(beat_q.size()) - pending >= int'(DEPTH)) ovf_model = 1'b1;
        else beat_q.push_back(bus.dm_rsp_data_i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid_i     = 1'b0;
    bus.dm_rsp_valid_i = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d);
    bus.dm_rsp_valid_i = 1'b1;
    bus.dm_rsp_data_i  = d;
  endtask

  task automatic issue(input logic ld, input logic st, input logic sg, input logic [1:0] sz,
                       input logic [63:0] exe, input logic [4:0] dst, input logic we,
                       input logic [31:0] pc);
    bus.in_valid_i = 1'b1; bus.in_load_i = ld; bus.in_store_i = st; bus.in_sign_i = sg;
    bus.in_size_i = sz; bus.in_exe_result_i = exe; bus.in_dest_i = dst; bus.in_we_i = we;
    bus.in_pc_i = pc;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.wb_valid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(bus.wb_valid_o), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    bus.in_valid_i = 1'b0;
    bus.dm_rsp_data_i = '0;
    bus.wb_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_wb_valid", 64'(bus.wb_valid_o), 0);
    check("rst_fwd_dest", 64'(bus.fwd_dest_o), 0);
    check("rst_fwd_ok", 64'(bus.fwd_data_ok_o), 0);
    check("rst_ls", 64'(bus.ls_o), 0);
    check("rst_ovf", 64'(bus.rsp_ovf_o), 0);
    check("rst_result", bus.wb_result_o, 0);
    step(); rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(bus.in_ready_o), 1);

    // Signed byte load at offset 3, beat presented with the request.
    step(); idle(); issue(1, 0, 1, 2'd0, 64'h1003, 5'd3, 1, 32'h100); beat(64'h80FF_0000);
    @(negedge clk); check("lb_accept", 64'(bus.in_ready_o), 1);
    step(); idle();
    @(negedge clk); check("lb_wait", 64'(bus.wb_valid_o), 0);
    step();
    @(negedge clk);
    check("lb_full", 64'(bus.wb_valid_o), 1);
    check("lb_result", bus.wb_result_o, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_misalign", 64'(bus.wb_misalign_o), 0);

    // Load with an empty FIFO waits for a late beat.
    step(); idle(); issue(1, 0, 0, 2'd2, 64'h2004, 5'd7, 1, 32'h200);
    step(); idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("wait_valid", 64'(bus.wb_valid_o), 0);
      check("wait_ready", 64'(bus.in_ready_o), 0);
      check("wait_fwd_dest", 64'(bus.fwd_dest_o), 7);
      check("wait_fwd_ok", 64'(bus.fwd_data_ok_o), 0);
      check("wait_ls", 64'(bus.ls_o), 1);
      step(); idle();
      if (i == 4) beat(64'h1234_5678_9ABC_DEF0);
    end
    step(); idle();
    wait_valid("wait_done");
    check("wait_fwd_ok_full", 64'(bus.fwd_data_ok_o), 1);
    check("wait_fwd_data", bus.fwd_data_o, 64'h1234_5678);
    check("wait_result", bus.wb_result_o, 64'h1234_5678);

    // Four back-to-back ALU ops.
    for (int i = 0; i < 4; i++) begin
      step(); idle(); issue(0, 0, 0, 2'd2, 64'h100 + 64'(i), 5'(i + 1), 1, 32'h300 + 32'(4 * i));
      @(negedge clk);
      check("b2b_ready", 64'(bus.in_ready_o), 1);
      if (i > 0) begin
        check("b2b_valid", 64'(bus.wb_valid_o), 1);
        check("b2b_fwd", bus.fwd_data_o, 64'h100 + 64'(i - 1));
      end
    end
    step(); idle();
    @(negedge clk); check("b2b_valid_last", 64'(bus.wb_valid_o), 1);
    step();
    @(negedge clk); check("b2b_drained", 64'(bus.wb_valid_o), 0);

    // Three beats into a two-entry FIFO: third is dropped.
    for (int i = 0; i < 3; i++) begin
      step(); idle(); beat(64'hAAAA_0000_0000_0001 + 64'(i));
    end
    step(); idle();
    @(negedge clk); check("ovf_set", 64'(bus.rsp_ovf_o), 1);
    step(); idle(); issue(1, 0, 0, 2'd3, 64'h3000, 5'd10, 1, 32'h400);
    step(); idle(); issue(1, 0, 0, 2'd3, 64'h3008, 5'd11, 1, 32'h404);
    @(negedge clk); check("ovf_beat1", bus.wb_result_o, 64'hAAAA_0000_0000_0001);
    step(); idle();
    @(negedge clk); check("ovf_beat2", bus.wb_result_o, 64'hAAAA_0000_0000_0002);
    check("ovf_sticky", 64'(bus.rsp_ovf_o), 1);

    // Misaligned double, then unsigned half at offset 6.
    step(); idle(); issue(1, 0, 0, 2'd3, 64'h4004, 5'd12, 1, 32'h500); beat(64'hFEDC_BA98_7654_3210);
    step(); idle();
    wait_valid("ld_mis_valid");
    check("ld_misalign", 64'(bus.wb_misalign_o), 1);
    check("ld_result", bus.wb_result_o, 64'hFEDC_BA98_7654_3210);
    step(); idle(); issue(1, 0, 0, 2'd1, 64'h5006, 5'd13, 1, 32'h504); beat(64'hABCD_0000_0000_0000);
    step(); idle();
    wait_valid("lhu_valid");
    check("lhu_result", bus.wb_result_o, 64'h0000_0000_0000_ABCD);
    check("lhu_misalign", 64'(bus.wb_misalign_o), 0);

    // Reset during WAIT with one beat queued.
    step(); idle(); issue(1, 0, 0, 2'd3, 64'h6000, 5'd14, 1, 32'h600);
    step(); idle();
    @(negedge clk); check("rw_wait", 64'(bus.wb_valid_o), 0);
    step(); beat(64'hDEAD_BEEF_0000_0001);
    step(); idle();
    rst = 1'b1;
    #1;
    check("rw_rst_valid", 64'(bus.wb_valid_o), 0);
    check("rw_rst_fwd", 64'(bus.fwd_dest_o), 0);
    check("rw_rst_ls", 64'(bus.ls_o), 0);
    check("rw_rst_ovf", 64'(bus.rsp_ovf_o), 0);
    check("rw_rst_result", bus.wb_result_o, 0);
    step(); rst = 1'b0;
    @(negedge clk); check("rw_ready", 64'(bus.in_ready_o), 1);
    step(); idle(); issue(1, 0, 0, 2'd3, 64'h7000, 5'd15, 1, 32'h700);
    step(); idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rw_no_stale", 64'(bus.wb_valid_o), 0);
    end
    step(); idle(); beat(64'h0123_4567_89AB_CDEF);
    step(); idle();
    wait_valid("rw_fresh_valid");
    check("rw_fresh_result", bus.wb_result_o, 64'h0123_4567_89AB_CDEF);

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      logic ld;
      step(); idle();
      if ($urandom_range(3) != 0) begin
        ld = 1'($urandom_range(1));
        issue(ld, ~ld & 1'($urandom_range(1)), 1'($urandom_range(1)), 2'($urandom_range(3)),
              {$urandom, $urandom}, 5'($urandom), 1'($urandom_range(1)), $urandom);
      end
      bus.wb_ready_i = ($urandom_range(3) != 0);
      if ($urandom_range(2) == 0) beat({$urandom, $urandom});
    end
    step(); idle();
    bus.wb_ready_i = 1'b1;
    for (int c = 0; c < 64 && exp_q.size() != 0; c++) begin
      beat({$urandom, $urandom});
      step(); idle();
    end
    step();
    @(negedge clk);
    check("drain", 64'(exp_q.size()), 0);
    check("ovf_final", 64'(bus.rsp_ovf_o), 64'(ovf_model));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
